conv_1x1_layer_sched: RTL and testbench

Sequencer for one 1x1 convolution layer of the DeepLabV3+ pipeline. It sits between on-chip weight/feature-map memories and the 1x1 conv layer top (loop-data / conv / channel-adder / align-FIFO chain). For each output channel, it loads that channel's CHANNEL_NUM_IN weights, then streams the input feature map in channel-interleaved order. It counts finished results to detect layer completion.

---
 rtl/conv_1x1_layer_sched.sv | 148 ++++++++++++++
 tb/tb_conv_1x1_layer_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/conv_1x1_layer_sched.sv
// Schedules one 1x1 convolution layer: per output channel, loads CIN weights then
// streams the feature map channel-interleaved, and counts results to detect completion.
module conv_1x1_layer_sched #(
   parameter int DATA_WIDTH      = 32,
   parameter int IMAGE_WIDTH     = 16,
   parameter int IMAGE_HEIGHT    = 16,
   parameter int CHANNEL_NUM_IN  = 256,
   parameter int CHANNEL_NUM_OUT = 512,
   parameter int WADDR_WIDTH     = 17,
   parameter int PADDR_WIDTH     = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic                   w_rd_en,
   output logic [WADDR_WIDTH-1:0] w_rd_addr,
   input  logic [DATA_WIDTH-1:0]  w_rd_data,
   output logic                   p_rd_en,
   output logic [PADDR_WIDTH-1:0] p_rd_addr,
   input  logic [DATA_WIDTH-1:0]  p_rd_data,
   output logic                   valid_weight_out,
   output logic [DATA_WIDTH-1:0]  weight_out,
   output logic                   valid_pxl_out,
   output logic [DATA_WIDTH-1:0]  pxl_out,
   input  logic                   result_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int TOTAL      = IMAGE_SIZE * CHANNEL_NUM_OUT;
   localparam int CI_W       = (CHANNEL_NUM_IN  > 1) ? $clog2(CHANNEL_NUM_IN)  : 1;
   localparam int PX_W       = (IMAGE_SIZE      > 1) ? $clog2(IMAGE_SIZE)      : 1;
   localparam int OC_W       = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
   localparam int CNT_W      = $clog2(TOTAL + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD_W = 3'd1;
   localparam logic [2:0] STREAM = 3'd2;
   localparam logic [2:0] DRAIN  = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   logic [2:0]       state_reg;
   logic [OC_W-1:0]  oc_reg;
   logic [CI_W-1:0]  ci_reg;
   logic [PX_W-1:0]  px_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             err_reg;
   logic             vw_reg;
   logic             vp_reg;

   logic last_ci;
   logic last_px;
   logic last_oc;
   logic cnt_full;

   assign last_ci  = (ci_reg == CI_W'(CHANNEL_NUM_IN - 1));
   assign last_px  = (px_reg == PX_W'(IMAGE_SIZE - 1));
   assign last_oc  = (oc_reg == OC_W'(CHANNEL_NUM_OUT - 1));
   assign cnt_full = (cnt_reg == CNT_W'(TOTAL));

   assign w_rd_en   = (state_reg == LOAD_W);
   assign p_rd_en   = (state_reg == STREAM);
   assign w_rd_addr = w_rd_en ? (WADDR_WIDTH'(oc_reg) * WADDR_WIDTH'(CHANNEL_NUM_IN)
                                 + WADDR_WIDTH'(ci_reg)) : '0;
   assign p_rd_addr = p_rd_en ? (PADDR_WIDTH'(ci_reg) * PADDR_WIDTH'(IMAGE_SIZE)
                                 + PADDR_WIDTH'(px_reg)) : '0;

   assign busy = (state_reg == LOAD_W) || (state_reg == STREAM) || (state_reg == DRAIN);
   assign done = (state_reg == DONE);
   assign err  = err_reg;

   // Memory data is only forwarded alongside its valid so idle outputs stay at zero.
   assign valid_weight_out = vw_reg;
   assign valid_pxl_out    = vp_reg;
   assign weight_out       = vw_reg ? w_rd_data : '0;
   assign pxl_out          = vp_reg ? p_rd_data : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         oc_reg    <= '0;
         ci_reg    <= '0;
         px_reg    <= '0;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
         vw_reg    <= 1'b0;
         vp_reg    <= 1'b0;
      end else begin
         vw_reg <= w_rd_en;
         vp_reg <= p_rd_en;
         if (result_valid && busy && !cnt_full)
            cnt_reg <= cnt_reg + 1'b1;
         if (result_valid && ((state_reg == IDLE) || (state_reg == DONE)))
            err_reg <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg <= LOAD_W;
                  oc_reg    <= '0;
                  ci_reg    <= '0;
                  px_reg    <= '0;
                  cnt_reg   <= '0;
               end
            end
            LOAD_W: begin
               if (last_ci) begin
                  ci_reg    <= '0;
                  state_reg <= STREAM;
               end else begin
                  ci_reg <= ci_reg + 1'b1;
               end
            end
            STREAM: begin
               // Channel is the inner loop so each pixel's CIN inputs arrive together.
               if (last_ci) begin
                  ci_reg <= '0;
                  if (last_px) begin
                     px_reg <= '0;
                     if (last_oc) begin
                        state_reg <= DRAIN;
                     end else begin
                        oc_reg    <= oc_reg + 1'b1;
                        state_reg <= LOAD_W;
                     end
                  end else begin
                     px_reg <= px_reg + 1'b1;
                  end
               end else begin
                  ci_reg <= ci_reg + 1'b1;
               end
            end
            DRAIN: begin
               if (cnt_full)
                  state_reg <= DONE;
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_1x1_layer_sched.sv
// Directed bench for conv_1x1_layer_sched (CIN=4, COUT=2, 2x2 image): a queue of
// expected reads is filled at start and drained one entry per cycle against the strobes.
module tb_conv_1x1_layer_sched;

   localparam int DW = 32;
   localparam int WA = 17;
   localparam int PA = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          w_rd_en;
   logic [WA-1:0] w_rd_addr;
   logic [DW-1:0] w_rd_data = '0;
   logic          p_rd_en;
   logic [PA-1:0] p_rd_addr;
   logic [DW-1:0] p_rd_data = '0;
   logic          valid_weight_out;
   logic [DW-1:0] weight_out;
   logic          valid_pxl_out;
   logic [DW-1:0] pxl_out;
   logic          result_valid;
   logic          busy;
   logic          done;
   logic          err;

   conv_1x1_layer_sched #(
      .DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2),
      .CHANNEL_NUM_IN(4), .CHANNEL_NUM_OUT(2),
      .WADDR_WIDTH(WA), .PADDR_WIDTH(PA)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
      .p_rd_en(p_rd_en), .p_rd_addr(p_rd_addr), .p_rd_data(p_rd_data),
      .valid_weight_out(valid_weight_out), .weight_out(weight_out),
      .valid_pxl_out(valid_pxl_out), .pxl_out(pxl_out),
      .result_valid(result_valid), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Memory model: read data equals the address, one cycle after the strobe.
   always @(posedge clk) begin
      if (w_rd_en) w_rd_data <= DW'(w_rd_addr);
      if (p_rd_en) p_rd_data <= DW'(p_rd_addr);
   end

   typedef struct packed {
      logic        is_w;
      logic [31:0] addr;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_e;
   logic last_v;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
         $error("%s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_layer();
      for (int oc = 0; oc < 2; oc++) begin
         for (int ci = 0; ci < 4; ci++) exp_q.push_back('{1'b1, 32'(oc * 4 + ci)});
         for (int px = 0; px < 4; px++)
            for (int ci = 0; ci < 4; ci++) exp_q.push_back('{1'b0, 32'(ci * 4 + px)});
      end
   endtask

   // Compares strobes with the queue head and valids/data with the previous cycle's read.
   task automatic chk_cycle();
      exp_t e;
      check("overlap", 32'(w_rd_en & p_rd_en), 32'd0);
      check("valid_weight_out", 32'(valid_weight_out), 32'(last_v & last_e.is_w));
      check("weight_out", weight_out, (last_v && last_e.is_w) ? last_e.addr : 32'd0);
      check("valid_pxl_out", 32'(valid_pxl_out), 32'(last_v & !last_e.is_w));
      check("pxl_out", pxl_out, (last_v && !last_e.is_w) ? last_e.addr : 32'd0);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("w_rd_en", 32'(w_rd_en), 32'(e.is_w));
         check("p_rd_en", 32'(p_rd_en), 32'(!e.is_w));
         if (e.is_w) check("w_rd_addr", 32'(w_rd_addr), e.addr);
         else        check("p_rd_addr", 32'(p_rd_addr), e.addr);
         check("busy_run", 32'(busy), 32'd1);
         $display("read %s addr=%0d", e.is_w ? "w" : "p", e.addr);
         last_e = e;
         last_v = 1'b1;
      end else begin
         check("w_rd_en_idle", 32'(w_rd_en), 32'd0);
         check("p_rd_en_idle", 32'(p_rd_en), 32'd0);
         last_v = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk_cycle();
   endtask

   task automatic chk_quiet(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_w_rd_addr"}, 32'(w_rd_addr), 32'd0);
      check({tag, "_p_rd_addr"}, 32'(p_rd_addr), 32'd0);
   endtask

   // Runs a whole layer (optionally with an ignored start mid-stream) and its result phase.
   task automatic run_full(input bit extra_start);
      start = 1'b1;
      push_layer();
      step();
      start = 1'b0;
      for (int c = 2; c <= 40; c++) begin
         step();
         start = (extra_start && c == 8);
      end
      start = 1'b0;
      step();
      check("drain_busy", 32'(busy), 32'd1);
      for (int r = 0; r < 8; r++) begin
         result_valid = 1'b1;
         step();
         check("pre_done", 32'(done), 32'd0);
      end
      result_valid = 1'b0;
      check("drain_busy_full", 32'(busy), 32'd1);
      step();
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_err", 32'(err), 32'd0);
      $display("layer done");
      step();
      check("post_done", 32'(done), 32'd0);
      check("post_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      reset        = 1'b0;
      start        = 1'b0;
      result_valid = 1'b0;
      last_v       = 1'b0;
      last_e       = '0;

      repeat (3) begin
         step();
         chk_quiet("reset");
         check("reset_err", 32'(err), 32'd0);
      end
      reset = 1'b1;
      repeat (20) begin
         step();
         chk_quiet("idle");
         check("idle_err", 32'(err), 32'd0);
      end

      run_full(1'b1);

      // Back-to-back start, aborted by reset after ten cycles.
      start = 1'b1;
      push_layer();
      step();
      start = 1'b0;
      repeat (9) step();
      reset = 1'b0;
      exp_q.delete();
      last_v = 1'b0;
      step();
      chk_quiet("abort");
      $display("abort applied");
      reset = 1'b1;
      step();
      chk_quiet("abort_idle");

      run_full(1'b0);

      result_valid = 1'b1;
      step();
      result_valid = 1'b0;
      check("err_set", 32'(err), 32'd1);
      repeat (5) step();
      check("err_sticky", 32'(err), 32'd1);
      reset = 1'b0;
      step();
      check("err_cleared", 32'(err), 32'd0);
      reset = 1'b1;
      step();
      chk_quiet("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
